// File: rtl/fp16_align_add_norm.sv
// Sequential align / add / normalize / round core for the binary16 adder.
// Takes ordered operands and returns a packed result over a valid/ready handshake.
module fp16_align_add_norm #(
  parameter int MAX_ALIGN       = 14,
  parameter int FLUSH_SUBNORMAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        As,
  input  logic        Bs,
  input  logic        swap,
  input  logic [4:0]  moves,
  input  logic [4:0]  exp,
  input  logic [9:0]  Am,
  input  logic [9:0]  Bm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        ovf,
  output logic        inexact
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] ROUND = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [4:0] MAX_A = 5'(MAX_ALIGN);

  logic [2:0]  state;
  logic [13:0] sl;
  logic [13:0] ss;
  logic [14:0] m;
  logic [4:0]  e;
  logic [4:0]  cnt;
  logic        rs;
  logic        sub;
  logic        big;
  logic        zero;
  logic        flush;

  logic [4:0]  es;
  logic [4:0]  a;
  logic [13:0] sl_in;
  logic [13:0] ss_in;
  logic [13:0] ss_add;
  logic [14:0] sum;
  logic        inc;
  logic [10:0] frac_rnd;
  logic [4:0]  e_inc;

  assign in_ready = (state == IDLE);

  // Operand preparation, adder and rounding increment.
  always_comb begin
    es = exp - moves;
    if (moves > MAX_A) begin
      a = MAX_A;
    end else begin
      a = moves;
    end
    if ((FLUSH_SUBNORMAL != 0) && (exp == 5'd0)) begin
      sl_in = 14'd0;
    end else begin
      sl_in = {exp != 5'd0, Am, 3'b000};
    end
    if (es != 5'd0) begin
      ss_in = {1'b1, Bm, 3'b000};
    end else begin
      ss_in = 14'd0;
    end
    // Shifts beyond the cap leave only a sticky contribution.
    if (big) begin
      ss_add = {13'd0, |ss};
    end else begin
      ss_add = ss;
    end
    if (sub) begin
      sum = {1'b0, sl} - {1'b0, ss_add};
    end else begin
      sum = {1'b0, sl} + {1'b0, ss_add};
    end
    inc      = m[2] & (m[1] | m[0] | m[3]);
    frac_rnd = {1'b0, m[12:3]} + {10'd0, inc};
    e_inc    = e + 5'd1;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= 16'h0000;
      ovf       <= 1'b0;
      inexact   <= 1'b0;
      sl        <= 14'd0;
      ss        <= 14'd0;
      m         <= 15'd0;
      e         <= 5'd0;
      cnt       <= 5'd0;
      rs        <= 1'b0;
      sub       <= 1'b0;
      big       <= 1'b0;
      zero      <= 1'b0;
      flush     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rs    <= swap ? Bs : As;
            sub   <= As ^ Bs;
            sl    <= sl_in;
            ss    <= ss_in;
            e     <= exp;
            cnt   <= a;
            big   <= (moves > MAX_A);
            zero  <= 1'b0;
            flush <= 1'b0;
            if (exp == 5'h1F) begin
              result  <= {swap ? Bs : As, 5'h1F, Am};
              ovf     <= 1'b0;
              inexact <= 1'b0;
              state   <= DONE;
            end else if (a == 5'd0) begin
              state <= ADD;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          ss  <= {1'b0, ss[13:2], ss[1] | ss[0]};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= ADD;
          end
        end
        ADD: begin
          m     <= sum;
          state <= NORM;
        end
        NORM: begin
          if (m == 15'd0) begin
            zero  <= 1'b1;
            state <= ROUND;
          end else if (m[14]) begin
            m     <= {1'b0, m[14:2], m[1] | m[0]};
            e     <= e_inc;
            state <= ROUND;
          end else if (m[13]) begin
            state <= ROUND;
          end else if (e == 5'd1) begin
            flush <= 1'b1;
            state <= ROUND;
          end else begin
            m <= {m[13:0], 1'b0};
            e <= e - 5'd1;
            if (m[12]) begin
              state <= ROUND;
            end
          end
        end
        ROUND: begin
          state <= DONE;
          if (zero) begin
            result  <= 16'h0000;
            ovf     <= 1'b0;
            inexact <= 1'b0;
          end else if (flush) begin
            result  <= {rs, 15'd0};
            ovf     <= 1'b0;
            inexact <= 1'b1;
          end else if ((e == 5'h1F) || (frac_rnd[10] && (e_inc == 5'h1F))) begin
            result  <= {rs, 5'h1F, 10'd0};
            ovf     <= 1'b1;
            inexact <= 1'b1;
          end else if (frac_rnd[10]) begin
            result  <= {rs, e_inc, 10'd0};
            ovf     <= 1'b0;
            inexact <= |m[2:0];
          end else begin
            result  <= {rs, e, frac_rnd[9:0]};
            ovf     <= 1'b0;
            inexact <= |m[2:0];
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_align_add_norm.sv
// Directed-vector bench for fp16_align_add_norm: result, flags, latency,
// output stall and mid-operation reset.
module tb_fp16_align_add_norm;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        As;
  logic        Bs;
  logic        swap;
  logic [4:0]  moves;
  logic [4:0]  exp;
  logic [9:0]  Am;
  logic [9:0]  Bm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf;
  logic        inexact;

  int n_vec;
  int n_err;

  fp16_align_add_norm #(.MAX_ALIGN(14), .FLUSH_SUBNORMAL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .As(As), .Bs(Bs), .swap(swap), .moves(moves), .exp(exp), .Am(Am), .Bm(Bm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ovf(ovf), .inexact(inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Apply one bundle, wait for the result, check it, then complete the handshake.
  // want_lat < 0 skips the latency comparison.
  task automatic run_op(input string tag, input logic as_i, input logic bs_i, input logic sw_i,
                        input logic [4:0] mv_i, input logic [4:0] ex_i, input logic [9:0] am_i,
                        input logic [9:0] bm_i, input logic [15:0] want_res, input logic want_ovf,
                        input logic want_inx, input int want_lat, input int stall);
    int cyc;
    check_val({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    As = as_i; Bs = bs_i; swap = sw_i; moves = mv_i; exp = ex_i; Am = am_i; Bm = bm_i;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (want_lat >= 0) begin
      check_val({tag, ".latency"}, 32'(cyc), 32'(want_lat));
    end
    check_val({tag, ".result"}, 32'(result), 32'(want_res));
    check_val({tag, ".ovf"}, 32'(ovf), 32'(want_ovf));
    check_val({tag, ".inexact"}, 32'(inexact), 32'(want_inx));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check_val({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      check_val({tag, ".stall_result"}, 32'(result), 32'(want_res));
      check_val({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val({tag, ".drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    As = 1'b0; Bs = 1'b0; swap = 1'b0; moves = 5'd0; exp = 5'd0; Am = 10'd0; Bm = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst.in_ready", 32'(in_ready), 32'd1);
    check_val("rst.out_valid", 32'(out_valid), 32'd0);
    check_val("rst.result", 32'(result), 32'd0);
    check_val("rst.ovf", 32'(ovf), 32'd0);
    check_val("rst.inexact", 32'(inexact), 32'd0);

    //      tag          As    Bs    swap  moves  exp     Am        Bm        result    ovf   inx   lat stall
    run_op("one_plus_one", 1'b0, 1'b0, 1'b0, 5'd0,  5'd15, 10'h000, 10'h000, 16'h4000, 1'b0, 1'b0, 4,  0);
    run_op("one_min_half", 1'b0, 1'b1, 1'b0, 5'd1,  5'd15, 10'h000, 10'h000, 16'h3800, 1'b0, 1'b0, 5,  0);
    run_op("neg_swap",     1'b0, 1'b1, 1'b1, 5'd1,  5'd15, 10'h000, 10'h000, 16'hB800, 1'b0, 1'b0, 5,  0);
    run_op("cancel",       1'b0, 1'b1, 1'b0, 5'd0,  5'd15, 10'h001, 10'h000, 16'h1400, 1'b0, 1'b0, 13, 0);
    run_op("tie_even",     1'b0, 1'b0, 1'b0, 5'd11, 5'd15, 10'h000, 10'h000, 16'h3C00, 1'b0, 1'b1, 15, 0);
    run_op("tie_up",       1'b0, 1'b0, 1'b0, 5'd11, 5'd15, 10'h001, 10'h000, 16'h3C02, 1'b0, 1'b1, 15, 0);
    run_op("rnd_carry",    1'b0, 1'b0, 1'b0, 5'd11, 5'd15, 10'h3FF, 10'h000, 16'h4000, 1'b0, 1'b1, 15, 0);
    run_op("cap_sticky",   1'b0, 1'b0, 1'b0, 5'd20, 5'd15, 10'h000, 10'h3FF, 16'h3C00, 1'b0, 1'b1, 18, 0);
    run_op("overflow",     1'b0, 1'b0, 1'b0, 5'd0,  5'd30, 10'h3FF, 10'h3FF, 16'h7C00, 1'b1, 1'b1, 4,  0);
    run_op("exact_zero",   1'b0, 1'b1, 1'b0, 5'd0,  5'd15, 10'h000, 10'h000, 16'h0000, 1'b0, 1'b0, 4,  0);
    run_op("flush",        1'b0, 1'b1, 1'b0, 5'd0,  5'd1,  10'h001, 10'h000, 16'h0000, 1'b0, 1'b1, -1, 0);
    run_op("passthru",     1'b1, 1'b0, 1'b0, 5'd3,  5'd31, 10'h155, 10'h000, 16'hFD55, 1'b0, 1'b0, 1,  0);
    run_op("stall",        1'b0, 1'b0, 1'b0, 5'd0,  5'd15, 10'h000, 10'h000, 16'h4000, 1'b0, 1'b0, 4,  5);

    // Reset during ALIGN must abandon the operation with no stale output.
    As = 1'b0; Bs = 1'b0; swap = 1'b0; moves = 5'd11; exp = 5'd15; Am = 10'h001; Bm = 10'h000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst.in_ready", 32'(in_ready), 32'd1);
    check_val("mid_rst.result", 32'(result), 32'd0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val("mid_rst.stale", 32'(seen), 32'd0);
    run_op("after_rst",    1'b0, 1'b1, 1'b0, 5'd1,  5'd15, 10'h000, 10'h000, 16'h3800, 1'b0, 1'b0, 5,  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp16_align_add_norm.md
Name: fp16_align_add_norm

Overview:
- Sequential add/subtract core for the binary16 adder.
- Sits directly downstream of the operand-ordering stage. It consumes that stage's ordered operands: larger/smaller fraction, larger exponent, exponent difference, signs and swap flag.
- Aligns the smaller significand, adds or subtracts, normalizes, rounds to nearest-even, and returns a packed 16-bit result over a valid/ready handshake.
- Shifts run one bit per cycle, so latency is data-dependent.

Parameters:
- MAX_ALIGN, 14, alignment-shift cap; larger moves collapse into sticky.
- FLUSH_SUBNORMAL, 1, fixed at 1; exponent-0 operands and results flush to zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept a bundle
- As  in  1  sign of A
- Bs  in  1  sign of B
- swap  in  1  1 = B is the larger-magnitude operand
- moves  in  5  exponent difference, larger minus smaller
- exp  in  5  exponent of larger operand
- Am  in  10  fraction of larger operand
- Bm  in  10  fraction of smaller operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  16  packed binary16 sum
- ovf  out  1  result overflowed to infinity
- inexact  out  1  nonzero guard/round/sticky was discarded

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; result=0; ovf=0; inexact=0. Reset mid-operation abandons the operation, returns to IDLE and drops any pending output.
- Capture: inputs are captured when in_valid && in_ready. in_ready = (state==IDLE).
- Significands:
  - SL = {exp!=0, Am} plus 3 zero bits (G,R,S), 14 bits total.
  - Smaller exponent = exp-moves. SS = {(exp-moves)!=0, Bm}, 000; SS is forced to 0 when exp-moves==0.
- Signs:
  - Result sign rs = swap ? Bs : As.
  - Effective subtract when As != Bs.
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE → DONE when exp==31: passthrough, result={rs,5'h1F,Am}, ovf=0, inexact=0.
- IDLE → ADD when the shift count a=min(moves,MAX_ALIGN) is 0; otherwise IDLE → ALIGN.
- ALIGN: exactly a cycles. Each cycle SS shifts right 1 bit; the bit shifted out ORs into S (sticky bit).
  - If moves > MAX_ALIGN, after the a cycles SS collapses to sticky = OR of all its bits.
- ADD (1 cycle): 15-bit sum = SL+SS, or SL-SS (never negative, since SL ≥ SS).
- NORM:
  - Zero sum: result +0 (0x0000); go directly to ROUND with zero kept.
  - Carry (bit 14 set): right shift 1, sticky preserved, exp+1; 1 cycle.
  - Already normalized: 1 cycle.
  - Otherwise: left shift 1 and exp-1 per cycle until bit 13 is set; n cycles.
  - If exp would reach 0: flush to {rs,15'b0}, inexact=1.
- ROUND (1 cycle):
  - Round to nearest, ties to even: increment when G && (R||S||lsb).
  - Rounding carry-out: significand becomes 0x400 and exp+1.
  - exp==31 after NORM or ROUND: result={rs,5'h1F,10'b0}, ovf=1, inexact=1.
  - inexact = G|R|S, or flush/overflow.
- DONE:
  - out_valid=1; result, ovf and inexact are held stable until out_ready.
  - On out_valid && out_ready: out_valid drops, state → IDLE. A new capture is possible the following cycle; there is no same-cycle turnaround.
  - out_ready held low stalls indefinitely.
- Latency, from the capture edge to the edge that sets out_valid: 3 + a + max(n,1) cycles. Passthrough latency is 1.

Test Plan:
- 1.0+1.0 (exp=15, Am=0, Bm=0, moves=0, As=Bs=0, swap=0) → result 0x4000, ovf=0, inexact=0, out_valid 4 cycles after capture.
- 1.0−0.5 (exp=15, moves=1, Am=Bm=0, As=0, Bs=1, swap=0) → 0x3800, latency 5.
- Cancellation: exp=15, Am=1, Bm=0, moves=0, As=0, Bs=1 → 0x1400, latency 13 (n=10).
- Tie rounding: exp=15, Am=0, Bm=0, moves=11, same signs → 0x3C00, inexact=1, latency 15. Then moves=20, Bm=0x3FF → 0x3C00, inexact=1, latency 18 (a capped at 14).
- Overflow: exp=30, Am=Bm=0x3FF, moves=0, same signs → 0x7C00, ovf=1, inexact=1.
- Handshake/reset: hold out_ready=0 for 5 cycles after out_valid → result stable and in_ready=0. Pulse rst during ALIGN → next cycle out_valid=0, in_ready=1, result=0, and no stale result appears.
